// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants and types for the seven-segment display controller.
// Segment codes are {a,b,c,d,e,f,g}, active-high, a = bit 6.
package seg_display_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_PLUS  = 7'b0000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHOW
  } state_t;

  function automatic int bcd_w(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Request/display bundle between the board top and the display controller.
// master drives the request, slave is the controller.
interface seg_display_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
);

  logic              load;
  logic [DATA_W-1:0] value;
  logic              signed_mode;
  logic              dec_mode;
  logic              busy;
  logic              valid;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_sel;
  logic [6:0]        neg_seg;

  modport master (
    output load, value, signed_mode, dec_mode,
    input  busy, valid, overflow, seg, digit_sel, neg_seg
  );

  modport slave (
    input  load, value, signed_mode, dec_mode,
    output busy, valid, overflow, seg, digit_sel, neg_seg
  );

endinterface

// File: rtl/seg_display_ctrl_decode.sv
// Nibble to seven-segment pattern decoder.
// Purely combinational; sits on the scan mux output.
module seg_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // map one hex digit to its segment pattern
  always_comb begin
    unique case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller: hex / double-dabble decimal.
// Optional leading-zero blanking: SEG_DISPLAY_LEAD_ZERO_BLANK_EN.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 16
) (
  input logic clk,
  input logic rst,
  seg_display_ctrl_if.slave bus
);

  localparam int BCD_W = bcd_w(DIGITS);
  localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STW   = $clog2(DATA_W + 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [STW-1:0]    r_step;
  logic              r_neg_p;
  logic              r_ovf_acc;
  logic              r_busy;
  logic              r_valid;
  logic [BCD_W-1:0]  r_dig;
  logic              r_neg;
  logic              r_ovf;
  logic [SCW-1:0]    r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DIGITS-1:0] r_sel;
  logic [6:0]        r_seg;

  logic                     w_accept;
  logic                     w_neg_in;
  logic [DATA_W-1:0]        w_mag;
  logic [DATA_W+BCD_W-1:0]  w_ext;
  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W-1:0]         w_bcd_sh;
  logic                     w_out;
  logic                     w_commit;
  logic [BCD_W-1:0]         w_dig_nxt;
  logic                     w_neg_nxt;
  logic                     w_ovf_nxt;
  logic                     w_adv;
  logic [IW-1:0]            w_idx_nxt;
  logic [SCW-1:0]           w_cnt_nxt;
  logic [3:0]               w_nib;
  logic [6:0]               w_dec_seg;
  logic [6:0]               w_seg_nxt;

  assign w_accept = bus.load && (r_state != CONV);
  assign w_neg_in = bus.signed_mode && bus.value[DATA_W-1];
  assign w_mag    = w_neg_in ? -bus.value : bus.value;
  assign w_ext    = {{BCD_W{1'b0}}, w_mag};
  assign w_commit = (r_state == CONV) && (r_step == STW'(DATA_W));

  // one add-3-then-shift step of the BCD register
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_sh = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
    w_out    = w_adj[BCD_W-1];
  end

  // display contents as they will be after this edge
  always_comb begin
    w_dig_nxt = r_dig;
    w_neg_nxt = r_neg;
    w_ovf_nxt = r_ovf;
    if (w_accept && !bus.dec_mode) begin
      w_dig_nxt = w_ext[BCD_W-1:0];
      w_neg_nxt = w_neg_in;
      w_ovf_nxt = |(w_ext >> BCD_W);
    end else if (w_commit) begin
      w_dig_nxt = r_bcd;
      w_neg_nxt = r_neg_p;
      w_ovf_nxt = r_ovf_acc;
    end
  end

  // scan position after this edge; scan starts once out of reset
  always_comb begin
    w_adv     = (|r_sel) && (r_cnt == SCW'(SCAN_DIV - 1));
    w_cnt_nxt = ((|r_sel) && !w_adv) ? r_cnt + SCW'(1) : '0;
    w_idx_nxt = r_idx;
    if (w_adv)
      w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    w_nib = w_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
  end

  seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

`ifdef SEG_DISPLAY_LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_lz;
  logic              w_hi_zero;

  // blank zero digits above the highest nonzero one, never digit 0
  always_comb begin
    w_lz      = '0;
    w_hi_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_hi_zero = w_hi_zero && (w_dig_nxt[4*i +: 4] == 4'd0);
      w_lz[i]   = w_hi_zero && !w_ovf_nxt;
    end
    w_seg_nxt = w_lz[w_idx_nxt] ? SEG_BLANK : w_dec_seg;
  end
`else
  assign w_seg_nxt = w_dec_seg;
`endif

  // conversion FSM with registered busy/valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_step    <= '0;
      r_neg_p   <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, SHOW: begin
          if (bus.load) begin
            if (bus.dec_mode) begin
              r_state   <= CONV;
              r_busy    <= 1'b1;
              r_valid   <= 1'b0;
              r_bin     <= w_mag;
              r_bcd     <= '0;
              r_step    <= '0;
              r_neg_p   <= w_neg_in;
              r_ovf_acc <= 1'b0;
            end else begin
              r_state <= SHOW;
              r_valid <= 1'b1;
            end
          end
        end
        CONV: begin
          if (w_commit) begin
            r_state <= SHOW;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_bin     <= r_bin << 1;
            r_bcd     <= w_bcd_sh;
            r_ovf_acc <= r_ovf_acc | w_out;
            r_step    <= r_step + STW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // committed digits, sign and overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dig <= '0;
      r_neg <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_dig <= w_dig_nxt;
      r_neg <= w_neg_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // free-running scan; seg follows the newly selected digit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sel <= '0;
      r_seg <= SEG_BLANK;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_sel <= DIGITS'(1) << w_idx_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.valid     = r_valid;
  assign bus.overflow  = r_ovf;
  assign bus.seg       = r_seg;
  assign bus.digit_sel = r_sel;
  assign bus.neg_seg   = r_neg ? SEG_MINUS : SEG_PLUS;

endmodule
